// File: rtl/sort_job_ctrl.sv
// Job controller for the parallel-load bubble-sort engine: collects up to NUM
// stream elements, loads and starts the sorter under a watchdog, then streams
// the sorted result downstream smallest-first.
module sort_job_ctrl #(
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned NUM     = 7,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    s_valid,
    input  logic [DATA_W-1:0]       s_data,
    input  logic                    s_last,
    output logic                    s_ready,
    output logic                    m_valid,
    output logic [DATA_W-1:0]       m_data,
    output logic                    m_last,
    input  logic                    m_ready,
    input  logic                    flush,
    output logic                    busy,
    output logic                    err,
    output logic [NUM-1:0]          srt_load,
    output logic [DATA_W*NUM-1:0]   srt_wdata,
    output logic                    srt_start,
    output logic                    srt_abort,
    input  logic [DATA_W*NUM-1:0]   srt_rdata,
    input  logic                    srt_irq
);

    localparam int unsigned CNT_W = $clog2(NUM + 1);
    localparam int unsigned TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int unsigned BUS_W = DATA_W * NUM;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_START,
        S_WAIT,
        S_ABORT,
        S_DRAIN
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   r_idx;
    logic [TMR_W-1:0]   r_timer;
    logic [BUS_W-1:0]   r_buf;      // collection buffer, doubles as the padded sorter load word
    logic [BUS_W-1:0]   r_res;      // sorted result, lane 0 is the current output beat
    logic               r_err;
    logic               r_busy;
    logic               r_s_ready;
    logic               r_m_valid;
    logic               r_m_last;
    logic               r_srt_load;
    logic               r_srt_start;
    logic               r_srt_abort;

    state_t             w_state_nxt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [CNT_W-1:0]   w_idx_nxt;
    logic [TMR_W-1:0]   w_timer_nxt;
    logic [BUS_W-1:0]   w_buf_nxt;
    logic [BUS_W-1:0]   w_res_nxt;
    logic               w_err_nxt;
    logic               w_flush_abort;
    logic               w_busy_nxt;
    logic               w_s_ready_nxt;
    logic               w_m_valid_nxt;
    logic               w_m_last_nxt;
    logic               w_load_nxt;
    logic               w_start_nxt;
    logic               w_abort_nxt;

    // Next-state, datapath and next-output decode
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_idx_nxt     = r_idx;
        w_timer_nxt   = r_timer;
        w_buf_nxt     = r_buf;
        w_res_nxt     = r_res;
        w_err_nxt     = r_err;
        w_flush_abort = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (flush) begin
                    w_cnt_nxt = '0;
                end else if (s_valid) begin
                    // first element of a job pre-fills every lane with padding
                    if (r_cnt == '0) begin
                        w_buf_nxt = '1;
                    end
                    for (int unsigned i = 0; i < NUM; i++) begin
                        if (r_cnt == CNT_W'(i)) begin
                            w_buf_nxt[i*DATA_W +: DATA_W] = s_data;
                        end
                    end
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                    w_err_nxt = 1'b0;
                    if (s_last || (r_cnt == CNT_W'(NUM - 1))) begin
                        w_state_nxt = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                w_state_nxt = S_START;
            end
            S_START: begin
                w_timer_nxt = '0;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_timer_nxt = r_timer + TMR_W'(1);
                if (srt_irq) begin
                    w_res_nxt   = srt_rdata;
                    w_idx_nxt   = '0;
                    w_state_nxt = S_DRAIN;
                end else if (r_timer == TMR_W'(TIMEOUT - 1)) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = S_ABORT;
                end
            end
            S_ABORT: begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_IDLE;
            end
            S_DRAIN: begin
                if (m_ready) begin
                    w_res_nxt = r_res >> DATA_W;
                    w_idx_nxt = r_idx + CNT_W'(1);
                    if (r_idx == r_cnt - CNT_W'(1)) begin
                        w_cnt_nxt   = '0;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // flush outranks irq, timeout and handshake; only an in-flight sort needs aborting
        if (flush && (r_state != S_IDLE)) begin
            w_state_nxt   = S_IDLE;
            w_cnt_nxt     = '0;
            w_idx_nxt     = '0;
            w_res_nxt     = r_res;
            w_err_nxt     = r_err;
            w_flush_abort = (r_state == S_WAIT);
        end

        w_s_ready_nxt = (w_state_nxt == S_IDLE);
        w_m_valid_nxt = (w_state_nxt == S_DRAIN);
        w_m_last_nxt  = w_m_valid_nxt && (w_idx_nxt == w_cnt_nxt - CNT_W'(1));
        w_load_nxt    = (w_state_nxt == S_LOAD);
        w_start_nxt   = (w_state_nxt == S_START);
        w_abort_nxt   = w_flush_abort || (w_state_nxt == S_ABORT);
        w_busy_nxt    = (w_state_nxt != S_IDLE) || (w_cnt_nxt != '0);
    end

    // State, datapath and registered outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_idx       <= '0;
            r_timer     <= '0;
            r_buf       <= '0;
            r_res       <= '0;
            r_err       <= 1'b0;
            r_busy      <= 1'b0;
            r_s_ready   <= 1'b1;
            r_m_valid   <= 1'b0;
            r_m_last    <= 1'b0;
            r_srt_load  <= 1'b0;
            r_srt_start <= 1'b0;
            r_srt_abort <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_idx       <= w_idx_nxt;
            r_timer     <= w_timer_nxt;
            r_buf       <= w_buf_nxt;
            r_res       <= w_res_nxt;
            r_err       <= w_err_nxt;
            r_busy      <= w_busy_nxt;
            r_s_ready   <= w_s_ready_nxt;
            r_m_valid   <= w_m_valid_nxt;
            r_m_last    <= w_m_last_nxt;
            r_srt_load  <= w_load_nxt;
            r_srt_start <= w_start_nxt;
            r_srt_abort <= w_abort_nxt;
        end
    end

    assign s_ready   = r_s_ready;
    assign m_valid   = r_m_valid;
    assign m_data    = r_res[DATA_W-1:0];
    assign m_last    = r_m_last;
    assign busy      = r_busy;
    assign err       = r_err;
    assign srt_load  = {NUM{r_srt_load}};
    assign srt_wdata = r_buf;
    assign srt_start = r_srt_start;
    assign srt_abort = r_srt_abort;

endmodule

// File: tb/tb_sort_job_ctrl.sv
// Self-checking bench for sort_job_ctrl with a behavioural sorter peer and
// an expected-beat queue built from sorted job contents.
module tb_sort_job_ctrl;

    localparam int unsigned DW = 8;
    localparam int unsigned N  = 7;
    localparam int unsigned TO = 64;

    typedef logic [DW-1:0] byte_q_t[$];
    typedef struct {
        logic [DW-1:0] d;
        logic          last;
    } beat_t;

    logic              clk, rst;
    logic              s_valid, s_last, s_ready;
    logic [DW-1:0]     s_data;
    logic              m_valid, m_last, m_ready;
    logic [DW-1:0]     m_data;
    logic              flush, busy, err;
    logic [N-1:0]      srt_load;
    logic [DW*N-1:0]   srt_wdata, srt_rdata;
    logic              srt_start, srt_abort, srt_irq;

    int                vectors = 0;
    int                miscompares = 0;
    beat_t             exp_q[$];
    int                rdy_mode = 0;
    int                pat_i = 0;
    int                sort_lat = 3;
    bit                sorter_dead = 0;
    logic [DW*N-1:0]   last_wdata;

    sort_job_ctrl #(.DATA_W(DW), .NUM(N), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_data(s_data), .s_last(s_last), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_last(m_last), .m_ready(m_ready),
        .flush(flush), .busy(busy), .err(err),
        .srt_load(srt_load), .srt_wdata(srt_wdata), .srt_start(srt_start),
        .srt_abort(srt_abort), .srt_rdata(srt_rdata), .srt_irq(srt_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_note(input string nm, input string why);
        vectors++;
        miscompares++;
        $display("FAIL %s: %s", nm, why);
    endtask

    function automatic byte_q_t sort_q(input byte_q_t q);
        byte_q_t r = q;
        logic [DW-1:0] t;
        for (int i = 0; i < r.size(); i++)
            for (int j = 0; j + 1 < r.size() - i; j++)
                if (r[j] > r[j+1]) begin
                    t = r[j]; r[j] = r[j+1]; r[j+1] = t;
                end
        return r;
    endfunction

    function automatic logic [DW*N-1:0] pad(input byte_q_t d);
        logic [DW*N-1:0] w = '1;
        for (int i = 0; i < d.size(); i++) w[i*DW +: DW] = d[i];
        return w;
    endfunction

    function automatic logic [DW-1:0] rand_byte();
        case ($urandom_range(0, 4))
            0:       return 8'h00;
            1:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    function automatic byte_q_t rand_job(input int n);
        byte_q_t q;
        for (int i = 0; i < n; i++) q.push_back(rand_byte());
        return q;
    endfunction

    task automatic push_beats(input byte_q_t s);
        beat_t b;
        for (int i = 0; i < s.size(); i++) begin
            b.d = s[i];
            b.last = (i == s.size() - 1);
            exp_q.push_back(b);
        end
    endtask

    // behavioural sorter: latches lanes on load, answers sorted lanes after sort_lat cycles
    logic [DW-1:0] lanes [N];
    bit            pend;
    int            cd;

    function automatic logic [DW*N-1:0] sorted_lanes();
        byte_q_t q, s;
        logic [DW*N-1:0] w;
        for (int i = 0; i < N; i++) q.push_back(lanes[i]);
        s = sort_q(q);
        for (int i = 0; i < N; i++) w[i*DW +: DW] = s[i];
        return w;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            srt_irq   <= 1'b0;
            srt_rdata <= '0;
            pend      <= 1'b0;
            cd        <= 0;
        end else begin
            srt_irq <= 1'b0;
            if (srt_load == 7'h7F)
                for (int i = 0; i < N; i++) lanes[i] <= srt_wdata[i*DW +: DW];
            if (srt_abort) begin
                pend <= 1'b0;
            end else if (srt_start && !sorter_dead) begin
                if (sort_lat <= 1) begin
                    srt_irq   <= 1'b1;
                    srt_rdata <= sorted_lanes();
                end else begin
                    pend <= 1'b1;
                    cd   <= sort_lat - 1;
                end
            end else if (pend) begin
                if (cd == 1) begin
                    srt_irq   <= 1'b1;
                    srt_rdata <= sorted_lanes();
                    pend      <= 1'b0;
                end else begin
                    cd <= cd - 1;
                end
            end
        end
    end

    // downstream ready pattern generator
    initial begin
        m_ready = 1'b1;
        forever begin
            @(posedge clk); #1;
            case (rdy_mode)
                0:       m_ready = 1'b1;
                1:       m_ready = 1'($urandom_range(0, 1));
                2:       begin m_ready = ((pat_i % 4) == 0) || ((pat_i % 4) == 3); pat_i++; end
                default: m_ready = 1'b0;
            endcase
        end
    end

    // output stream checked against expected beats every cycle
    always @(negedge clk) begin
        if (rst && m_valid) begin
            if (exp_q.size() == 0) begin
                fail_note("unexpected_beat", $sformatf("got beat %0h, expected none", m_data));
            end else begin
                check("m_data", m_data, exp_q[0].d);
                check("m_last", m_last, exp_q[0].last);
                check("s_ready_in_drain", s_ready, 0);
                if (m_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic wait_accept();
        bit ok;
        int c = 0;
        forever begin
            ok = s_ready;
            tick();
            if (ok) break;
            c++;
            if (c > 300) begin
                fail_note("accept_wait", "s_ready never rose");
                break;
            end
        end
    endtask

    // returns in the srt_start cycle
    task automatic send_job(input byte_q_t d, input bit last7, input bit push, input bit gaps);
        int n = d.size();
        for (int i = 0; i < n; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) tick();
            s_valid = 1'b1;
            s_data  = d[i];
            s_last  = (i == n - 1) && ((n < N) || last7);
            wait_accept();
            s_valid = 1'b0;
            s_last  = 1'b0;
            if (i == 0) check("err_clear_on_accept", err, 0);
        end
        check("load_pulse", srt_load, 7'h7F);
        check("load_wdata", srt_wdata, pad(d));
        check("s_ready_in_load", s_ready, 0);
        last_wdata = srt_wdata;
        tick();
        check("start_pulse", srt_start, 1);
        check("load_single", srt_load, 0);
        if (push) push_beats(sort_q(d));
    endtask

    task automatic wait_done();
        int c = 0;
        while (!(exp_q.size() == 0 && s_ready && !busy)) begin
            tick();
            c++;
            if (c > 500) begin
                fail_note("job_done_wait", "job did not complete");
                break;
            end
        end
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_err"}, err, 0);
        check({tag, "_srt_load"}, srt_load, 0);
        check({tag, "_srt_start"}, srt_start, 0);
        check({tag, "_srt_abort"}, srt_abort, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_srt_wdata"}, srt_wdata, 0);
    endtask

    initial begin
        byte_q_t d;
        int c;
        rst = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0; flush = 1'b0;

        #2;
        check_reset_outs("rst");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("rst_s_ready", s_ready, 1);

        // full job with literal expectations and first-beat latency
        sort_lat = 4;
        d = '{8'd0, 8'd7, 8'd100, 8'd254, 8'd255, 8'd128, 8'd2};
        send_job(d, 1, 0, 0);
        check("t1_wdata", last_wdata, 56'h0280FFFE640700);
        d = '{8'd0, 8'd2, 8'd7, 8'd100, 8'd128, 8'd254, 8'd255};
        push_beats(d);
        c = 0;
        while (!m_valid && c < 100) begin tick(); c++; end
        check("t1_first_beat_latency", c, sort_lat + 1);
        wait_done();

        // short job: padding lanes and exactly three beats
        d = '{8'd9, 8'd3, 8'd5};
        send_job(d, 0, 0, 0);
        check("t2_pad_lanes", last_wdata[55:24], 32'hFFFFFFFF);
        check("t2_data_lanes", last_wdata[23:0], 24'h050309);
        d = '{8'd3, 8'd5, 8'd9};
        push_beats(d);
        wait_done();

        // backpressure 1,0,0,1
        rdy_mode = 2; pat_i = 0;
        send_job(rand_job(N), 0, 1, 0);
        wait_done();
        rdy_mode = 0;

        // irq arriving in the last watchdog cycle wins
        sort_lat = TO;
        send_job(rand_job(5), 0, 1, 0);
        wait_done();
        check("irq_at_timeout_err", err, 0);

        // watchdog abort
        sorter_dead = 1;
        send_job(rand_job(4), 0, 0, 0);
        c = 0;
        while (!srt_abort && c < 200) begin tick(); c++; end
        check("abort_latency", c, TO + 1);
        check("abort_err", err, 1);
        tick();
        check("abort_single", srt_abort, 0);
        check("abort_s_ready", s_ready, 1);
        check("abort_err_sticky", err, 1);
        check("abort_busy", busy, 0);
        sorter_dead = 0;
        sort_lat = 6;
        send_job(rand_job(N), 1, 1, 1);
        wait_done();

        // flush together with srt_irq in WAIT
        sort_lat = 5;
        send_job(rand_job(6), 0, 0, 0);
        c = 0;
        while (!srt_irq && c < 100) begin tick(); c++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("flush_wait_abort", srt_abort, 1);
        check("flush_wait_s_ready", s_ready, 1);
        check("flush_wait_m_valid", m_valid, 0);
        check("flush_wait_err", err, 0);
        check("flush_wait_busy", busy, 0);
        tick();
        check("flush_wait_abort_single", srt_abort, 0);

        // flush while stalled in DRAIN: no abort pulse
        rdy_mode = 3;
        sort_lat = 2;
        send_job(rand_job(N), 0, 1, 0);
        c = 0;
        while (!m_valid && c < 100) begin tick(); c++; end
        flush = 1'b1;
        tick();
        flush = 1'b0;
        exp_q.delete();
        check("flush_drain_m_valid", m_valid, 0);
        check("flush_drain_s_ready", s_ready, 1);
        check("flush_drain_abort", srt_abort, 0);
        check("flush_drain_busy", busy, 0);
        rdy_mode = 0;

        // flush in IDLE drops a partial collection
        for (int i = 0; i < 3; i++) begin
            s_valid = 1'b1; s_data = rand_byte(); s_last = 1'b0;
            wait_accept();
            s_valid = 1'b0;
        end
        check("partial_busy", busy, 1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("partial_flushed_busy", busy, 0);
        send_job(rand_job(N), 0, 1, 0);
        wait_done();

        // randomized jobs
        for (int j = 0; j < 30; j++) begin
            sort_lat = $urandom_range(1, TO);
            rdy_mode = $urandom_range(0, 2);
            send_job(rand_job($urandom_range(1, N)), 1'($urandom_range(0, 1)), 1, 1);
            wait_done();
            repeat ($urandom_range(0, 3)) tick();
        end
        rdy_mode = 0;

        // reset mid-DRAIN after two beats
        sort_lat = 3;
        send_job(rand_job(N), 0, 1, 0);
        c = 0;
        while (exp_q.size() > N - 2 && c < 200) begin tick(); c++; end
        rst = 1'b0;
        #1;
        check_reset_outs("midrst");
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        tick();
        check("midrst_s_ready", s_ready, 1);
        send_job(rand_job(N), 0, 1, 0);
        wait_done();

        check("leftover_beats", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "bench timed out");
    end

endmodule

// File: doc/sort_job_ctrl.md
# sort_job_ctrl

Job controller that sequences the parallel-load bubble-sort engine (`bublesort`, DATA_W×NUM lanes) from a streaming interface. It collects up to NUM elements from an upstream valid/ready stream and loads them into the engine in one cycle. It then starts the sort, waits for completion under a watchdog, and streams the sorted result downstream smallest-first. It sits between the packet/stream fabric and the sorter and is the only block that drives the sorter's load/start/abort pins.

## Interface
- DATA_W, 8, element width
- NUM, 7, sorter lanes = max elements per job
- TIMEOUT, 64, cycles allowed in WAIT before abort (≥2)
- clk  in  1  clock, all logic on rising edge
- rst  in  1  asynchronous, active-low reset
- s_valid  in  1  upstream element valid
- s_data  in  DATA_W  upstream element
- s_last  in  1  marks final element of a job
- s_ready  out  1  upstream ready
- m_valid  out  1  sorted element valid
- m_data  out  DATA_W  sorted element
- m_last  out  1  final sorted element of job
- m_ready  in  1  downstream ready
- flush  in  1  discard current job
- busy  out  1  job in progress
- err  out  1  sticky: last job aborted by watchdog
- srt_load  out  NUM  per-lane load to sorter
- srt_wdata  out  DATA_W*NUM  lane i at bits [i*DATA_W +: DATA_W]
- srt_start  out  1  sort start pulse
- srt_abort  out  1  sort abort pulse
- srt_rdata  in  DATA_W*NUM  sorted lanes, lane 0 smallest
- srt_irq  in  1  one-cycle completion pulse; srt_rdata valid in that cycle

## Operation
- States: IDLE, LOAD, START, WAIT, ABORT, DRAIN.
- IDLE: s_ready=1. Each s_valid&s_ready writes buf[cnt] and increments cnt.
  - The accept with s_last=1 goes to LOAD.
  - The accept that makes cnt==NUM goes to LOAD even without s_last. Further elements belong to the next job.
- LOAD: srt_load = all ones for exactly one cycle. Lanes ≥cnt are driven with all-ones padding, so padding sorts to the top lanes. Then go to START.
- START: srt_start=1 for one cycle, timer cleared, then go to WAIT.
- WAIT: timer increments each cycle.
  - srt_irq: capture srt_rdata into res, clear idx, go to DRAIN.
  - timer==TIMEOUT-1 with no srt_irq: go to ABORT.
  - srt_irq in the same cycle as the timeout: srt_irq wins.
- ABORT: srt_abort=1 for one cycle, err set, job discarded, cnt cleared, go to IDLE.
- DRAIN: m_valid=1, m_data=res lane idx, m_last=(idx==cnt-1). Each m_valid&m_ready increments idx. The handshake on m_last clears cnt and goes to IDLE.
  - Only the first cnt lanes are emitted; padding is never output.
- flush (any state except IDLE):
  - In WAIT, pulse srt_abort for one cycle.
  - Discard the job, clear cnt/idx, return to IDLE the next cycle. err is unchanged.
  - flush wins over simultaneous srt_irq, timeout, or handshake.
  - flush in IDLE clears partially collected elements.
- err clears on the first upstream accept of the next job.
- busy = (state≠IDLE) | (cnt≠0).
- Unsigned compare is the sorter's concern; the controller performs no arithmetic on data.

## Timing
- Reset (async assert): state=IDLE, cnt/idx/timer=0.
  - s_ready=1 once reset is released.
  - m_valid, m_last, busy, err, srt_load, srt_start, srt_abort = 0.
  - m_data, srt_wdata = 0.
- Last element accepted at edge t: LOAD in cycle t+1, srt_start high in cycle t+2, WAIT from t+3.
- srt_irq in cycle w: m_valid high from cycle w+1. One element per cycle under continuous m_ready.
- m_data/m_last stable while m_valid & !m_ready.
- Timeout: srt_abort high in cycle t+3+TIMEOUT. s_ready high again the following cycle.
- s_ready=0 from LOAD until DRAIN completes. No overlap between jobs.
- Reset mid-job drops the job silently. Sorter outputs are deasserted immediately, with no abort pulse.

## Test plan
- Full job, s_data 0,7,100,254,255,128,2 (s_last on 2), DATA_W=8, NUM=7:
  - one srt_load=7'h7F cycle, then one srt_start;
  - output 0,2,7,100,128,254,255 with m_last only on 255.
- Short job 9,3,5 with s_last on 5:
  - srt_wdata lanes 3..6 = 8'hFF;
  - output 3,5,9, m_last on 9, exactly three beats.
- Backpressure: full job with m_ready toggling 1,0,0,1…
  - no beat lost or duplicated;
  - m_data held while stalled;
  - s_ready stays 0 until the last beat.
- Watchdog: sorter model never pulses srt_irq.
  - srt_abort is a single pulse exactly TIMEOUT cycles into WAIT;
  - err=1, and err clears on the next accept;
  - the next job sorts correctly.
- flush asserted in WAIT together with srt_irq: srt_abort pulses, no m_valid, IDLE next cycle, err=0.
- rst low mid-DRAIN after 2 of 7 beats:
  - all outputs take their reset values immediately;
  - a subsequent full job completes correctly.
